fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
- Framebuffer writer for the 40x30 tile display. The VGA scan-out reads this memory at byte base 0x400, one byte per 20x20-pixel tile, packed as RRRGGGBB.
- Accepts a rectangle-fill command: origin, size and 8-bit colour.
- Emits one byte-lane write per tile into the shared 32-bit video memory write port.
- Sits between the CPU's memory-mapped command registers and the video RAM write side.

Parameters:
- BASE_ADDR, 32'h400, byte address of tile (0,0).
- COLS, 40, tiles per row.
- ROWS, 30, tile rows.

Ports:
- clk50  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  6  origin column, 0..63.
- cmd_y  in  5  origin row, 0..31.
- cmd_w  in  6  width in tiles.
- cmd_h  in  5  height in tiles.
- cmd_color  in  8  fill byte {R[2:0],G[2:0],B[1:0]}.
- mem_we  out  1  write request.
- mem_addr  out  32  byte address of the current tile.
- mem_wdata  out  32  cmd_color replicated into all four lanes.
- mem_wbe  out  4  one-hot byte enable.
- mem_gnt  in  1  write accepted this cycle.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last command rejected (sticky).

Behaviour:
- Reset values: cmd_ready=0 during rst and 1 on the first cycle after it. mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, mem_wbe=0, busy=0, done=0, err=0. State returns to IDLE.
- States: IDLE, FILL, FIN.
- IDLE:
  - cmd_ready=1. Handshake occurs when cmd_valid && cmd_ready.
  - On handshake, latch all cmd_* fields and clear err.
  - Go to FILL if the effective rectangle is non-empty, else go to FIN.
- FILL:
  - busy=1 and mem_we=1.
  - mem_addr = BASE_ADDR + cur_y*COLS + cur_x. Compute in 32 bits with no truncation.
  - mem_wbe by mem_addr[1:0]: 0 -> 4'b1000 (bits 31:24), 1 -> 4'b0100, 2 -> 4'b0010, 3 -> 4'b0001. This matches the scan-out's big-endian lane order.
  - Address, data and byte enable are held stable while mem_gnt=0; no timeout.
  - On mem_gnt: cur_x++. When cur_x equals x0+w-1, wrap cur_x to x0 and increment cur_y.
  - A grant on the last tile (x0+w-1, y0+h-1) moves to FIN.
  - Write order is row-major. First write is presented the cycle after the handshake.
- FIN:
  - done=1 for exactly one cycle, busy=1, mem_we=0.
  - Next state is IDLE.
- cmd_ready is 0 in FILL and FIN. Commands offered then are ignored, not queued.
- Zero size (w==0 or h==0): no writes; done pulses 1 cycle after the handshake. This case is not an error.
- Out of bounds (x0+w>COLS or y0+h>ROWS): behaviour depends on CLIP_EN (see Optional Feature).
- Throughput: one tile per cycle when mem_gnt is held high. Total cycles from handshake to done = w*h + 1.
- Reset mid-FILL: the next edge returns to IDLE with mem_we=0. Tiles already written are not undone and no done pulse is generated.
- Simultaneous rst and cmd_valid: reset wins and the command is dropped.

Optional Feature:
- Macro: FB_RECT_FILL_CLIP_EN.
- Defined:
  - Out-of-bounds rectangles are clipped: w_eff = min(w, COLS-x0) and h_eff = min(h, ROWS-y0).
  - If x0>=COLS or y0>=ROWS, the rectangle is empty: no writes, done pulses.
  - err is never set.
- Undefined:
  - Any out-of-bounds rectangle is rejected: no writes, err=1, done pulses 1 cycle after the handshake.
  - err holds until the next accepted command.

Test Plan:
- Basic fill: rst, then cmd (x=0,y=0,w=2,h=2,color=8'hE0) with mem_gnt=1.
  - Expect 4 writes to 0x400, 0x401, 0x428, 0x429.
  - Expect wbe 1000, 0100, 1000, 0100 and wdata 32'hE0E0E0E0.
  - done pulses 5 cycles after the handshake.
- Grant stall: cmd (x=3,y=1,w=1,h=1), mem_gnt low for 3 cycles then high.
  - mem_addr=0x42B and wbe=0001 held stable for 4 cycles.
  - Exactly one write; done on the following cycle.
- Full screen: cmd (0,0,40,30,8'h1C).
  - 1200 writes in 1200 consecutive cycles.
  - Last address 0x8AF; done at cycle 1201.
- Out of bounds: cmd (x=38,y=0,w=4,h=1).
  - Without the macro: zero writes, err=1, done pulses.
  - With the macro: writes to 0x426, 0x427 only; err=0.
- Zero size and busy: cmd with w=0 gives no writes, done after 1 cycle, err=0. A cmd_valid held during FILL is not accepted until cmd_ready returns.
- Reset mid-fill: start (0,0,10,1), assert rst after 3 grants.
  - mem_we=0 on the next cycle, no done pulse.
  - cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle-fill engine writing one byte per tile into the 40x30 tile framebuffer.
// Define FB_RECT_FILL_CLIP_EN to clip out-of-bounds rectangles instead of rejecting them with err.
module fb_rect_fill #(
    parameter logic [31:0] BASE_ADDR = 32'h400,
    parameter int          COLS      = 40,
    parameter int          ROWS      = 30
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [5:0]  cmd_w,
    input  logic [4:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbe,
    input  logic        mem_gnt,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;
    localparam logic [6:0] C7 = 7'(COLS);
    localparam logic [5:0] R6 = 6'(ROWS);
    state_t state;
    logic [6:0] cx, cw, w_eff, x0, cur_x, x_last, nx;
    logic [5:0] cy, ch, h_eff, cur_y, y_last, ny;
    logic oob, empty, last;
    logic [31:0] a0, an;
    function automatic logic [31:0] tile_addr(input logic [6:0] x, input logic [5:0] y);
        return BASE_ADDR + 32'(y) * 32'(COLS) + 32'(x);
    endfunction
    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    function automatic logic [3:0] lane(input logic [31:0] a);
        return 4'b1000 >> a[1:0];
    endfunction
    always_comb begin
        cx = {1'b0, cmd_x};
        cw = {1'b0, cmd_w};
        cy = {1'b0, cmd_y};
        ch = {1'b0, cmd_h};
`ifdef FB_RECT_FILL_CLIP_EN
        oob   = 1'b0;
        w_eff = (cx >= C7) ? 7'd0 : (cw > C7 - cx) ? C7 - cx : cw;
        h_eff = (cy >= R6) ? 6'd0 : (ch > R6 - cy) ? R6 - cy : ch;
`else
        oob   = (cx + cw > C7) || (cy + ch > R6);
        w_eff = cw;
        h_eff = ch;
`endif
        empty = oob || w_eff == 7'd0 || h_eff == 6'd0;
        a0    = tile_addr(cx, cy);
        last  = cur_x == x_last && cur_y == y_last;
        nx    = (cur_x == x_last) ? x0 : cur_x + 7'd1;
        ny    = (cur_x == x_last) ? cur_y + 6'd1 : cur_y;
        an    = tile_addr(nx, ny);
    end
    always_ff @(posedge clk50) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            mem_wbe   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        err       <= oob;
                        x0        <= cx;
                        cur_x     <= cx;
                        cur_y     <= cy;
                        x_last    <= cx + w_eff - 7'd1;
                        y_last    <= cy + h_eff - 6'd1;
                        mem_wdata <= {4{cmd_color}};
                        mem_addr  <= a0;
                        mem_wbe   <= empty ? 4'b0000 : lane(a0);
                        mem_we    <= !empty;
                        done      <= empty;
                        state     <= empty ? FIN : FILL;
                    end
                end
                FILL: begin
                    if (mem_gnt) begin
                        if (last) begin
                            mem_we  <= 1'b0;
                            mem_wbe <= 4'b0000;
                            done    <= 1'b1;
                            state   <= FIN;
                        end else begin
                            cur_x    <= nx;
                            cur_y    <= ny;
                            mem_addr <= an;
                            mem_wbe  <= lane(an);
                        end
                    end
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: directed and random rectangle fills checked against a tile-list reference model.
module tb_fb_rect_fill;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam logic [31:0] BASE = 32'h400;
    logic clk50 = 0, rst = 1, cmd_valid = 0, mem_gnt = 0;
    logic cmd_ready, mem_we, busy, done, err;
    logic [5:0] cmd_x = 0, cmd_w = 0;
    logic [4:0] cmd_y = 0, cmd_h = 0;
    logic [7:0] cmd_color = 0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0] mem_wbe;
    int checks = 0, errors = 0;

    fb_rect_fill dut (
        .clk50(clk50), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .mem_gnt(mem_gnt), .busy(busy), .done(done), .err(err)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: grant always, 1: grant withheld for the first 3 write cycles, 2: random grant
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] col, input int mode, input bit hold);
        int we_, he_, c, n;
        bit oob_e, fin, stall;
        logic [31:0] q[$];
        logic [31:0] pa, pw, pd;
        oob_e = 0;
`ifdef FB_RECT_FILL_CLIP_EN
        we_ = (x >= COLS) ? 0 : (w < COLS - x ? w : COLS - x);
        he_ = (y >= ROWS) ? 0 : (h < ROWS - y ? h : ROWS - y);
`else
        oob_e = (x + w > COLS) || (y + h > ROWS);
        we_ = oob_e ? 0 : w;
        he_ = oob_e ? 0 : h;
`endif
        for (int r = y; r < y + he_; r++)
            for (int k = x; k < x + we_; k++)
                q.push_back(BASE + 32'(r * COLS + k));
        n = q.size();
        c = 0;
        @(negedge clk50);
        while (!cmd_ready && c < 20) begin
            @(negedge clk50);
            c++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 1);
        cmd_x = 6'(x); cmd_y = 5'(y); cmd_w = 6'(w); cmd_h = 5'(h); cmd_color = col;
        cmd_valid = 1;
        mem_gnt = 0;
        c = 0; fin = 0; stall = 0; pa = 0; pw = 0; pd = 0;
        while (!fin && c < 5000) begin
            @(negedge clk50);
            c++;
            if (!hold) cmd_valid = 0;
            if (stall) begin
                chk("hold_addr", mem_addr, pa);
                chk("hold_wbe", 32'(mem_wbe), pw);
                chk("hold_wdata", mem_wdata, pd);
            end
            if (done) begin
                fin = 1;
                chk("fin_we", 32'(mem_we), 0);
                chk("fin_busy", 32'(busy), 1);
                mem_gnt = 0;
            end else if (mem_we) begin
                chk("fill_ready_busy", 32'({cmd_ready, busy}), 1);
                mem_gnt = (mode == 0) ? 1'b1 : (mode == 1) ? (c >= 4) : 1'($urandom_range(0, 1));
                if (q.size() == 0) chk("extra_write", 1, 0);
                else begin
                    chk("addr", mem_addr, q[0]);
                    chk("wbe", 32'(mem_wbe), 32'(1) << (3 - (q[0] % 4)));
                    chk("wdata", mem_wdata, {col, col, col, col});
                    if (mem_gnt) void'(q.pop_front());
                end
                stall = !mem_gnt;
                pa = mem_addr; pw = 32'(mem_wbe); pd = mem_wdata;
            end else begin
                mem_gnt = 0;
                stall = 0;
            end
        end
        cmd_valid = 0;
        mem_gnt = 0;
        chk("done_seen", 32'(fin), 1);
        chk("writes_left", q.size(), 0);
        chk("err", 32'(err), 32'(oob_e));
        if (mode == 0) chk("latency", c, n + 1);
        if (mode == 1) chk("stall_latency", c, n + 4);
        @(negedge clk50);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk50);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wbe", 32'(mem_wbe), 0);
        chk("rst_busy_done_err", 32'({busy, done, err}), 0);
        rst = 0;
        @(negedge clk50);
        chk("ready_after_rst", 32'(cmd_ready), 1);

        run_cmd(0, 0, 2, 2, 8'hE0, 0, 0);
        run_cmd(3, 1, 1, 1, 8'h5A, 1, 0);
        run_cmd(0, 0, 40, 30, 8'h1C, 0, 0);
        run_cmd(38, 0, 4, 1, 8'h33, 0, 0);
        run_cmd(5, 5, 0, 3, 8'h77, 0, 0);
        run_cmd(2, 3, 6, 2, 8'hA5, 0, 1);
        run_cmd(39, 29, 1, 1, 8'hFF, 2, 0);
        run_cmd(45, 2, 3, 1, 8'h12, 0, 0);
        run_cmd(1, 1, 3, 3, 8'h81, 0, 0);

        // Reset during a fill: writes stop at once and no done pulse appears.
        @(negedge clk50);
        cmd_x = 0; cmd_y = 0; cmd_w = 10; cmd_h = 1; cmd_color = 8'h44;
        cmd_valid = 1; mem_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            cmd_valid = 0;
            chk("mid_we", 32'(mem_we), 1);
        end
        @(negedge clk50);
        chk("mid_addr", mem_addr, BASE + 3);
        rst = 1;
        @(negedge clk50);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        rst = 0; mem_gnt = 0;
        @(negedge clk50);
        chk("mid_ready_after", 32'(cmd_ready), 1);
        chk("mid_no_done", 32'(done), 0);

        // Command offered together with reset is dropped.
        cmd_w = 2; cmd_h = 1; cmd_valid = 1; rst = 1;
        @(negedge clk50);
        rst = 0; cmd_valid = 0;
        repeat (2) @(negedge clk50);
        chk("rst_cmd_dropped", 32'({mem_we, busy, done}), 0);

        for (int i = 0; i < 20; i++)
            run_cmd($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 12),
                    $urandom_range(0, 8), 8'($urandom), 2, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
